gpio_clk_out: RTL and testbench

- Avalon-MM slave output port: the write-side counterpart of the read-only input PIO.
- Drives WIDTH output pins from a software-written data register.
- Pin 0 can also be handed to a hardware burst generator that emits N clock pulses at a programmable rate, for bit-banged SD-card/serial clocking from the Nios.
- Sits on the system interconnect alongside the input PIOs.

---
 rtl/gpio_clk_out.sv | 174 +++++++++++++++++
 tb/tb_gpio_clk_out.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/gpio_clk_out.sv
// Avalon-MM output PIO. Pin 0 can be driven by a hardware clock-burst generator.
// Optional `GPIO_CLK_OUT_IRQ_EN adds an irq output and STATUS bit2 irq_enable.
module gpio_clk_out #(
    parameter int               WIDTH       = 8,
    parameter int               DIV_W       = 16,
    parameter int               DIV_RESET   = 62,
    parameter int               CNT_W       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
`ifdef GPIO_CLK_OUT_IRQ_EN
    ,
    output logic             irq
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOW  = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;

    logic [WIDTH-1:0] r_data;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_dl;
    logic [DIV_W-1:0] r_hc;
    logic [CNT_W-1:0] r_rem;
    logic [1:0]       r_state;
    logic             r_done;
    logic [31:0]      r_readdata;
    logic [WIDTH-1:0] r_out;
    logic             r_irq_en;

    logic             w_wr;
    logic             w_wr_data;
    logic             w_wr_div;
    logic             w_wr_cnt;
    logic             w_wr_stat;
    logic [CNT_W-1:0] w_cnt_val;
    logic             w_abort;
    logic             w_clr_done;
    logic             w_hc_end;
    logic             w_busy;
    logic             w_last;
    logic [31:0]      w_rdata;
    logic [WIDTH-1:0] w_out;
    logic             w_unused;

    assign w_wr       = chipselect & ~write_n;
    assign w_wr_data  = w_wr & (address == 2'd0);
    assign w_wr_div   = w_wr & (address == 2'd1);
    assign w_wr_cnt   = w_wr & (address == 2'd2);
    assign w_wr_stat  = w_wr & (address == 2'd3);
    assign w_cnt_val  = writedata[CNT_W-1:0];
    assign w_busy     = (r_state != S_IDLE);
    assign w_abort    = w_wr_stat & writedata[0] & w_busy;
    assign w_clr_done = w_wr_stat & writedata[1];
    assign w_hc_end   = (r_hc == r_dl);
    // Final half-period of the final pulse; an abort in this cycle suppresses done.
    assign w_last     = (r_state == S_HIGH) & w_hc_end & (r_rem == CNT_W'(1)) & ~w_abort;
    assign w_unused   = &{1'b0, writedata};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data <= RESET_VALUE;
            r_div  <= DIV_W'(DIV_RESET);
        end else begin
            if (w_wr_data) r_data <= writedata[WIDTH-1:0];
            if (w_wr_div)  r_div  <= writedata[DIV_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_dl    <= '0;
            r_hc    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_wr_cnt && (w_cnt_val != '0)) begin
                        r_rem   <= w_cnt_val;
                        r_dl    <= r_div;
                        r_hc    <= '0;
                        r_state <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                        r_rem   <= '0;
                    end else if (w_hc_end) begin
                        r_hc    <= '0;
                        r_state <= S_HIGH;
                    end else begin
                        r_hc <= r_hc + DIV_W'(1);
                    end
                end
                S_HIGH: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                        r_rem   <= '0;
                    end else if (w_hc_end) begin
                        r_rem   <= r_rem - CNT_W'(1);
                        r_hc    <= '0;
                        r_state <= (r_rem == CNT_W'(1)) ? S_IDLE : S_LOW;
                    end else begin
                        r_hc <= r_hc + DIV_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)        r_done <= 1'b0;
        else if (w_last)     r_done <= 1'b1;
        else if (w_clr_done) r_done <= 1'b0;
    end

`ifdef GPIO_CLK_OUT_IRQ_EN
    logic r_irq;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_stat) r_irq_en <= writedata[2];
            r_irq <= r_done & r_irq_en;
        end
    end

    assign irq = r_irq;
`else
    assign r_irq_en = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        case (address)
            2'd0:    w_rdata = 32'(r_data);
            2'd1:    w_rdata = 32'(r_div);
            2'd2:    w_rdata = 32'(r_rem);
            default: w_rdata = {29'd0, r_irq_en, r_done, w_busy};
        endcase
    end

    always_comb begin
        w_out    = r_data;
        w_out[0] = w_busy ? (r_state == S_HIGH) : r_data[0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
            r_out      <= RESET_VALUE;
        end else begin
            r_readdata <= w_rdata;
            r_out      <= w_out;
        end
    end

    assign readdata = r_readdata;
    assign out_port = r_out;

endmodule

// File: tb/tb_gpio_clk_out.sv
// Scoreboard bench for gpio_clk_out: per-cycle pin expectations and queued read results.
module tb_gpio_clk_out;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
`ifdef GPIO_CLK_OUT_IRQ_EN
    logic        irq;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  pin_q[$];
    logic [31:0] rd_q[$];
    string       rd_tag_q[$];

    gpio_clk_out #(
        .WIDTH(8),
        .DIV_W(16),
        .DIV_RESET(62),
        .CNT_W(16),
        .RESET_VALUE(8'h00)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .out_port(out_port)
`ifdef GPIO_CLK_OUT_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Every out_port value is checked just after a rising edge while expectations are queued.
    initial begin
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (pin_q.size() > 0) begin
                e = pin_q.pop_front();
                check_val("out_port", 32'(out_port), 32'(e));
            end
        end
    end

    // Bus tasks are entered and left on a falling edge.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string tag);
        rd_q.push_back(exp);
        rd_tag_q.push_back(tag);
        address    = a;
        chipselect = 1'b1;
        @(posedge clk);
        #1;
        check_val(rd_tag_q.pop_front(), readdata, rd_q.pop_front());
        @(negedge clk);
        chipselect = 1'b0;
    endtask

    // Expected pins from the edge of the starting COUNT write to the first idle cycle after the burst.
    task automatic push_burst(input logic [7:0] d, input int unsigned dl, input int unsigned n);
        logic [7:0] lo;
        logic [7:0] hi;
        lo = d & 8'hFE;
        hi = d | 8'h01;
        pin_q.push_back(d);
        for (int unsigned p = 0; p < n; p++) begin
            for (int unsigned c = 0; c <= dl; c++) pin_q.push_back(lo);
            for (int unsigned c = 0; c <= dl; c++) pin_q.push_back(hi);
        end
        pin_q.push_back(d);
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (3) @(negedge clk);
        check_val("rst_readdata", readdata, 32'h0);
        check_val("rst_out_port", 32'(out_port), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        rd(2'd1, 32'd62, "div_rst");
        rd(2'd0, 32'h0,  "data_rst");
        rd(2'd3, 32'h0,  "status_rst");
        rd(2'd2, 32'h0,  "count_rst");

        pin_q.push_back(8'h00);
        pin_q.push_back(8'hA5);
        wr(2'd0, 32'h0000_00A5);
        rd(2'd0, 32'hA5, "data_rb");

        wr(2'd0, 32'hFFFF_FF5A);
        rd(2'd0, 32'h5A, "data_mask");
        wr(2'd1, 32'h1234_FFFF);
        rd(2'd1, 32'hFFFF, "div_max");

        // DIV=1, COUNT=3: alternate COUNT and STATUS reads over the burst
        wr(2'd0, 32'hA4);
        wr(2'd1, 32'd1);
        push_burst(8'hA4, 1, 3);
        wr(2'd2, 32'd3);
        for (int k = 0; k <= 12; k++) begin
            if (k % 2 == 0) rd(2'd2, (k >= 12) ? 32'd0 : 32'(3 - k / 4), "count_rem");
            else            rd(2'd3, 32'h1, "status_busy");
        end
        rd(2'd3, 32'h2, "status_done");
        wr(2'd3, 32'h2);
        rd(2'd3, 32'h0, "done_clr");
        wr(2'd3, 32'h1);
        rd(2'd3, 32'h0, "abort_idle");

        // DIV=0, COUNT=5; DIV and COUNT rewritten mid-burst
        wr(2'd1, 32'd0);
        push_burst(8'hA4, 0, 5);
        wr(2'd2, 32'd5);
        wr(2'd1, 32'd9);
        wr(2'd2, 32'd7);
        rd(2'd1, 32'd9, "div_busy_wr");
        rd(2'd2, 32'd4, "count_mid");
        for (int k = 4; k <= 11; k++) rd(2'd3, (k < 10) ? 32'h1 : 32'h2, "status_b2");

        // COUNT=100 with DIV=9, aborted during the first low phase
        wr(2'd3, 32'h2);
        wr(2'd0, 32'hA5);
        wr(2'd1, 32'd9);
        pin_q.push_back(8'hA5);
        for (int c = 0; c < 10; c++) pin_q.push_back(8'hA4);
        pin_q.push_back(8'hA5);
        wr(2'd2, 32'd100);
        repeat (9) @(negedge clk);
        wr(2'd3, 32'h1);
        rd(2'd3, 32'h0, "abort_status");
        rd(2'd2, 32'h0, "abort_count");

        wr(2'd2, 32'h0001_0000);
        rd(2'd3, 32'h0, "count0_ignored");

`ifdef GPIO_CLK_OUT_IRQ_EN
        wr(2'd1, 32'd0);
        wr(2'd3, 32'h4);
        rd(2'd3, 32'h4, "irqen_rb");
        wr(2'd2, 32'd1);
        @(negedge clk);
        @(negedge clk);
        check_val("irq_pre", 32'(irq), 32'h0);
        @(negedge clk);
        check_val("irq_set", 32'(irq), 32'h1);
        wr(2'd2, 32'd1);
        @(negedge clk);
        wr(2'd3, 32'h6);
        check_val("irq_hold", 32'(irq), 32'h1);
        rd(2'd3, 32'h6, "done_set_wins");
        check_val("irq_hold2", 32'(irq), 32'h1);
        wr(2'd3, 32'h0);
        @(negedge clk);
        check_val("irq_en_clr", 32'(irq), 32'h0);
        rd(2'd3, 32'h2, "done_kept");
        wr(2'd3, 32'h2);
`endif

        // Asynchronous reset in the middle of a burst
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h3C);
        wr(2'd2, 32'd50);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_val("arst_readdata", readdata, 32'h0);
        check_val("arst_out_port", 32'(out_port), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(2'd1, 32'd62, "arst_div");
        rd(2'd3, 32'h0,  "arst_status");
        rd(2'd0, 32'h0,  "arst_data");
        rd(2'd2, 32'h0,  "arst_count");

        repeat (2) @(negedge clk);
        check_val("pin_q_drained", 32'(pin_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
